// File: rtl/seg7_display_scan_pkg.sv
// seg7_display_scan_pkg
// Shared constants for the 4-digit scanned 7-segment display:
//   - active-low segment patterns {g,f,e,d,c,b,a} for digits 0-9, dash, blank
//   - slot index type (slot 3 = hour tens ... slot 0 = minute units)
//   - active-low one-hot anode patterns per slot
package seg7_display_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    localparam logic [3:0] AN_SLOT3 = 4'b0111;
    localparam logic [3:0] AN_SLOT2 = 4'b1011;
    localparam logic [3:0] AN_SLOT1 = 4'b1101;
    localparam logic [3:0] AN_SLOT0 = 4'b1110;
    localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/seg7_display_scan_decoder.sv
// seg7_decoder
// Combinational BCD to active-low 7-segment decode. Values 10-15 show a dash.
//   digit : in  [3:0] value to display
//   seg   : out [6:0] active-low cathodes {g,f,e,d,c,b,a}
module seg7_decoder
    import seg7_display_scan_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_display_scan.sv
// seg7_display_scan
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A frame (slots 3,2,1,0) is latched in one cycle on entry to slot 3, so
// inputs changing mid-frame never tear the display.
//   clock        : in   system clock
//   reset        : in   asynchronous active-high reset
//   hour_out1    : in   [1:0] hour tens (0 is blanked as a leading zero)
//   hour_out0    : in   [3:0] hour units
//   minute_out1  : in   [3:0] minute tens
//   minute_out0  : in   [3:0] minute units
//   seconds      : in   [5:0] seconds; bit 0 drives the colon point
//   Alarm        : in   alarm active, flashes the display
//   an           : out  [3:0] active-low one-hot anodes, an[3] = hour tens
//   seg          : out  [6:0] active-low cathodes {g,f,e,d,c,b,a}
//   dp           : out  active-low decimal point (lit in slot 2)
// Build option: define ALARM_FLASH_EN to enable alarm flashing; otherwise the
// flash counter is absent and Alarm is ignored.
module seg7_display_scan
    import seg7_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int FLASH_DIV   = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] hour_out1,
    input  logic [3:0] hour_out0,
    input  logic [3:0] minute_out1,
    input  logic [3:0] minute_out0,
    input  logic [5:0] seconds,
    input  logic       Alarm,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [RW-1:0] ref_cnt;
    logic          ref_wrap;
    slot_t         slot;
    logic          started;   // low until the first frame has been latched
    logic          capture;

    logic [1:0] lat_h1;
    logic [3:0] lat_h0, lat_m1, lat_m0;
    logic       lat_colon;
    logic       blank_now;

    logic [4:0] unused_bits;
    assign unused_bits = seconds[5:1];

    assign ref_wrap = (ref_cnt == RW'(REFRESH_DIV - 1));
    // After reset the slot is already 3; the first wrap counts as entering it.
    assign capture  = ref_wrap && (!started || slot == SLOT0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ref_cnt <= '0;
            slot    <= SLOT3;
            started <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            if (ref_wrap) begin
                started <= 1'b1;
                if (started)
                    slot <= (slot == SLOT0) ? SLOT3 : slot_t'(slot - 2'd1);
            end
        end
    end

`ifdef ALARM_FLASH_EN
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    logic [FW-1:0] flash_cnt;
    logic          flash_phase;
    logic          lat_alarm;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else if (flash_cnt == FW'(FLASH_DIV - 1)) begin
            flash_cnt   <= '0;
            flash_phase <= ~flash_phase;
        end else begin
            flash_cnt   <= flash_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        lat_alarm <= 1'b0;
        else if (capture) lat_alarm <= Alarm;
    end

    assign blank_now = lat_alarm && !flash_phase;
`else
    logic unused_alarm;
    assign unused_alarm = Alarm;
    assign blank_now    = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_h1    <= '0;
            lat_h0    <= '0;
            lat_m1    <= '0;
            lat_m0    <= '0;
            lat_colon <= 1'b0;
        end else if (capture) begin
            lat_h1    <= hour_out1;
            lat_h0    <= hour_out0;
            lat_m1    <= minute_out1;
            lat_m0    <= minute_out0;
            lat_colon <= seconds[0];
        end
    end

    logic [3:0] digit;
    logic [6:0] seg_dec, seg_n;
    logic [3:0] an_n;
    logic       dp_n;

    seg7_decoder u_dec (
        .digit (digit),
        .seg   (seg_dec)
    );

    always_comb begin
        digit = 4'd0;
        an_n  = AN_OFF;
        case (slot)
            SLOT3: begin digit = {2'b00, lat_h1}; an_n = AN_SLOT3; end
            SLOT2: begin digit = lat_h0;          an_n = AN_SLOT2; end
            SLOT1: begin digit = lat_m1;          an_n = AN_SLOT1; end
            default: begin digit = lat_m0;        an_n = AN_SLOT0; end
        endcase
        seg_n = seg_dec;
        if (slot == SLOT3 && lat_h1 == 2'd0)
            seg_n = SEG_BLANK;
        dp_n = !(slot == SLOT2 && lat_colon);
        if (!started) begin
            an_n  = AN_OFF;
            seg_n = SEG_BLANK;
            dp_n  = 1'b1;
        end
        if (blank_now)
            an_n = AN_OFF;
    end

    // Registered outputs follow the slot index by exactly one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_n;
            seg <= seg_n;
            dp  <= dp_n;
        end
    end

endmodule

// File: tb/tb_seg7_display_scan.sv
// tb_seg7_display_scan
// Directed bench for seg7_display_scan with REFRESH_DIV=4, FLASH_DIV=16.
// Edge Ek is the k-th rising edge after reset release; slot 3 is first shown
// after E5 and each slot lasts 4 clocks.
module tb_seg7_display_scan;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] hour_out1;
    logic [3:0] hour_out0, minute_out1, minute_out0;
    logic [5:0] seconds;
    logic       Alarm;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int tests = 0;
    int fails = 0;

`ifdef ALARM_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    seg7_display_scan #(.REFRESH_DIV(4), .FLASH_DIV(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .hour_out1   (hour_out1),
        .hour_out0   (hour_out0),
        .minute_out1 (minute_out1),
        .minute_out0 (minute_out0),
        .seconds     (seconds),
        .Alarm       (Alarm),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_an;
        int s;
        reset = 1'b1;
        hour_out1 = 2'd1; hour_out0 = 4'd2; minute_out1 = 4'd3; minute_out0 = 4'd4;
        seconds = 6'd1; Alarm = 1'b0;
        tick(3);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'h1);

        @(negedge clock) reset = 1'b0;
        tick(4);  chk("prestart_an", {28'd0, an}, 32'hF);
        tick(1);  chk("s3_an", {28'd0, an}, 32'h7);  chk("s3_seg", {25'd0, seg}, 32'h79);
                  chk("s3_dp", {31'd0, dp}, 32'h1);
        tick(4);  chk("s2_an", {28'd0, an}, 32'hB);  chk("s2_seg", {25'd0, seg}, 32'h24);
                  chk("s2_dp", {31'd0, dp}, 32'h0);
        tick(4);  chk("s1_an", {28'd0, an}, 32'hD);  chk("s1_seg", {25'd0, seg}, 32'h30);
                  chk("s1_dp", {31'd0, dp}, 32'h1);
        tick(4);  chk("s0_an", {28'd0, an}, 32'hE);  chk("s0_seg", {25'd0, seg}, 32'h19);
        tick(4);  chk("wrap_an", {28'd0, an}, 32'h7); chk("wrap_seg", {25'd0, seg}, 32'h79);

        // E22: two cycles after slot-3 entry, change digits
        tick(1);  hour_out0 = 4'd9; minute_out0 = 4'd12;
        tick(3);  chk("hold_s2", {25'd0, seg}, 32'h24);
        tick(8);  chk("hold_s0", {25'd0, seg}, 32'h19);
        tick(8);  chk("new_s2", {25'd0, seg}, 32'h10);
        tick(8);  chk("dash_s0", {25'd0, seg}, 32'h3F);

        // leading-zero blanking, latched at E52
        hour_out1 = 2'd0; hour_out0 = 4'd7;
        tick(4);  chk("lz_an", {28'd0, an}, 32'h7);  chk("lz_seg", {25'd0, seg}, 32'h7F);
        tick(4);  chk("lz_s2", {25'd0, seg}, 32'h78);
        tick(4);  chk("mid_s1_an", {28'd0, an}, 32'hD);

        // asynchronous reset in the middle of slot 1
        #3 reset = 1'b1;
        #1;
        chk("async_an", {28'd0, an}, 32'hF);
        chk("async_seg", {25'd0, seg}, 32'h7F);
        chk("async_dp", {31'd0, dp}, 32'h1);
        hour_out1 = 2'd2; hour_out0 = 4'd3;
        @(negedge clock) reset = 1'b0;
        tick(4);  chk("rel_blank", {28'd0, an}, 32'hF);
        tick(1);  chk("rel_first_an", {28'd0, an}, 32'h7); chk("rel_first_seg", {25'd0, seg}, 32'h24);
        tick(4);  chk("rel_s2_seg", {25'd0, seg}, 32'h30);

        // alarm flashing (or continuous scan when flashing is built out)
        reset = 1'b1;
        Alarm = 1'b1;
        @(negedge clock) reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (k < 5 || (FLASH && (((k - 1) / 16) % 2 == 0))) begin
                exp_an = 4'hF;
            end else begin
                s = 3 - (((k - 5) / 4) % 4);
                exp_an = ~(4'b0001 << s);
            end
            chk($sformatf("alarm_an_E%0d", k), {28'd0, an}, {28'd0, exp_an});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_display_scan.md
SEG7_DISPLAY_SCAN -- requirements
Module: seg7_display_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot (1 ms at 100 MHz).
REQ-002 SHALL have parameter FLASH_DIV, default 25000000, meaning clock cycles per flash half-period (0.25 s).
REQ-003 SHALL have port clock  input  1  100 MHz system clock; the block uses one clock only.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port hour_out1  input  2  hour tens digit from the alarm clock.
REQ-006 SHALL have port hour_out0  input  4  hour units digit.
REQ-007 SHALL have port minute_out1  input  4  minute tens digit.
REQ-008 SHALL have port minute_out0  input  4  minute units digit.
REQ-009 SHALL have port seconds  input  6  binary seconds; bit 0 drives the colon point.
REQ-010 SHALL have port Alarm  input  1  alarm-active level; it flashes the display.
REQ-011 SHALL have port an  output  4  active-low one-hot digit anodes; an[3] is hour tens.
REQ-012 SHALL have port seg  output  7  active-low cathodes {g,f,e,d,c,b,a}.
REQ-013 SHALL have port dp  output  1  active-low decimal point (colon).

Function
REQ-014 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at the terminal count, slot index SHALL advance 3->2->1->0->3.
REQ-015 When slot index enters 3, the frame latch SHALL capture all four digit inputs, seconds[0] and Alarm in the same cycle; no mid-frame tearing.
REQ-016 an, seg and dp SHALL be registered, updating exactly 1 cycle after the slot index changes.
REQ-017 Decode SHALL map 0-9 to standard patterns and map values 10-15 to '-' (only g lit).
REQ-018 Leading zero: a latched hour tens of 0 SHALL blank slot 3 (seg=7'h7F, anode still asserted).
REQ-019 dp SHALL be 0 (lit) only in slot 2 when latched seconds[0]=1; otherwise 1.
REQ-020 Flash counter SHALL count 0..FLASH_DIV-1 and toggle flash_phase at wrap; it runs freely.
REQ-021 When latched Alarm=1 and flash_phase=0, an SHALL be 4'b1111; Alarm=0 SHALL display normally regardless of phase.
REQ-022 Digit inputs changing between frame latches SHALL have no effect until the next slot-3 entry.

Reset
REQ-023 While reset=1: an=4'b1111, seg=7'h7F, dp=1, slot index=3, both counters=0, flash_phase=0, frame latch all zero.
REQ-024 Reset deassertion SHALL restart from slot 3 with a fresh latch on the first refresh wrap; reset mid-frame discards the partial frame.

Configuration
REQ-025 Macro ALARM_FLASH_EN: when defined, REQ-020/021 apply; when undefined, the flash counter is removed, the Alarm input is ignored and the display never blanks.

Structure
REQ-026 Shared package SHALL hold the segment pattern constants (digits 0-9, dash, blank), the slot index type and the anode one-hot constants.
REQ-027 Decode SHALL be a combinational sub-module seg7_decoder (4-bit in, 7-bit active-low out).

Verification (REFRESH_DIV=4, FLASH_DIV=16)
REQ-028 Inputs 1,2,3,4, Alarm=0 -> an cycles 0111,1011,1101,1110 every 4 clocks; seg shows 1,2,3,4.
REQ-029 hour_out1=0, hour_out0=7 -> slot 3 seg=7'h7F with an=0111; slot 2 shows 7.
REQ-030 minute_out0=4'd12 -> slot 0 seg = dash pattern (7'h3F).
REQ-031 Change the digit 2 cycles after slot-3 entry -> old value held until the next slot-3 entry.
REQ-032 Alarm=1 (flash macro on) -> an=1111 for 16 clocks, then scanning for 16, repeating; macro off -> continuous scan.
REQ-033 Assert reset mid-slot 1 -> an=1111 and seg=7'h7F immediately (asynchronously); after release the first slot shown is 3.
